// File: rtl/bit4_full_adder_pkg.sv
// Shared constants and the two-input NAND helper for the registered ripple-carry adder.
package bit4_full_adder_pkg;

  localparam int unsigned FA_WIDTH = 4;

  function automatic logic nand2(input logic x, input logic y);
    return ~(x & y);
  endfunction

endpackage

// File: rtl/bit4_full_adder_nand.sv
// One-bit full adder made of nine two-input NAND gates; purely combinational.
module full_adder_nand
  import bit4_full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic n1, n2, n3, axb, n5, n6, n7;

  // First half: axb = a ^ b, with n1 = ~(a & b) reused for the carry.
  assign n1  = nand2(a, b);
  assign n2  = nand2(a, n1);
  assign n3  = nand2(b, n1);
  assign axb = nand2(n2, n3);

  // Second half folds in cin; cout = (a & b) | (axb & cin).
  assign n5   = nand2(axb, cin);
  assign n6   = nand2(axb, n5);
  assign n7   = nand2(cin, n5);
  assign sum  = nand2(n6, n7);
  assign cout = nand2(n5, n1);

endmodule

// File: rtl/bit4_full_adder.sv
// Registered WIDTH-bit ripple-carry adder: {cout_fa, sum_fa} <= a_fa + b_fa + c_fa[0].
module bit4_full_adder
  import bit4_full_adder_pkg::*;
#(
  parameter int WIDTH = FA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_fa,
  input  logic [WIDTH-1:0] b_fa,
  input  logic [WIDTH-1:0] c_fa,
  output logic [WIDTH-1:0] sum_fa,
  output logic             cout_fa
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_w;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;

  // Only bit 0 of c_fa is the carry-in; the upper bits are intentionally dropped.
  logic unused_c_fa;
  assign unused_c_fa = ^c_fa;

  assign carry[0] = c_fa[0];

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_nand u_fa (
      .a    (a_fa[i]),
      .b    (b_fa[i]),
      .cin  (carry[i]),
      .sum  (sum_w[i]),
      .cout (carry[i+1])
    );
  end

  always_comb begin
    sum_d  = sum_w;
    cout_d = carry[WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum_fa  = sum_q;
  assign cout_fa = cout_q;

endmodule

// File: tb/tb_bit4_full_adder.sv
// Scoreboard bench for bit4_full_adder: the driver queues expected {cout,sum}, the monitor checks one cycle later.
module tb_bit4_full_adder;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a_fa, b_fa, c_fa;
  logic [W-1:0] sum_fa;
  logic         cout_fa;

  logic [W:0] exp_q[$];
  string      tag_q[$];
  int         checks;
  int         failures;

  bit4_full_adder #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_fa    (a_fa),
    .b_fa    (b_fa),
    .c_fa    (c_fa),
    .sum_fa  (sum_fa),
    .cout_fa (cout_fa)
  );

  // Clock and reset: period 10, rising edges at 5, 15, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Direct comparison of the output pair against a bench-supplied value.
  task automatic check_now(input string name, input logic [W:0] exp);
    logic [W:0] got;
    got = {cout_fa, sum_fa};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b required=%b", name, got, exp);
    end
  endtask

  // Driver: present a vector after the falling edge and queue its result.
  task automatic drive(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W:0] exp);
    @(negedge clk);
    a_fa = a;
    b_fa = b;
    c_fa = c;
    exp_q.push_back(exp);
    tag_q.push_back(name);
  endtask

  task automatic randomize_inputs();
    a_fa = W'($urandom_range(0, 15));
    b_fa = W'($urandom_range(0, 15));
    c_fa = W'($urandom_range(0, 15));
  endtask

  // Monitor: just after each rising edge, pop one expectation if any is pending.
  initial begin
    logic [W:0] exp;
    string      tag;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        tag = tag_q.pop_front();
        check_now(tag, exp);
      end
    end
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W:0]   exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    a_fa     = '0;
    b_fa     = '0;
    c_fa     = '0;

    // Hand-computed directed vectors: {cout,sum}.
    vecs[0] = '{4'b1011, 4'b0111, 4'b0000, 5'b1_0010};
    vecs[1] = '{4'b0011, 4'b0011, 4'b0000, 5'b0_0110};
    vecs[2] = '{4'b0001, 4'b0001, 4'b1110, 5'b0_0010};
    vecs[3] = '{4'b1111, 4'b0000, 4'b0001, 5'b1_0000};
    vecs[4] = '{4'b1111, 4'b1111, 4'b0001, 5'b1_1111};
    vecs[5] = '{4'b0000, 4'b0000, 4'b0000, 5'b0_0000};

    // Async reset before any clock edge.
    #2;
    randomize_inputs();
    rst_n = 1'b0;
    #1;
    check_now("reset_immediate", 5'b0_0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      randomize_inputs();
      @(posedge clk);
      #1;
      check_now("reset_hold", 5'b0_0000);
    end

    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back vectors exercise latency and throughput together.
    drive("add_11_7", vecs[0].a, vecs[0].b, vecs[0].c, vecs[0].exp);
    drive("add_3_3", vecs[1].a, vecs[1].b, vecs[1].c, vecs[1].exp);
    #1;
    check_now("no_early_value", 5'b1_0010);
    for (int i = 2; i < 6; i++) begin
      drive($sformatf("directed_%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp);
    end

    // Reset mid-operation: the vector launched here is never expected.
    @(negedge clk);
    a_fa = 4'b1111;
    b_fa = 4'b1111;
    c_fa = 4'b0001;
    #2;
    rst_n = 1'b0;
    #1;
    check_now("midop_reset_clear", 5'b0_0000);
    @(posedge clk);
    #1;
    check_now("midop_reset_hold", 5'b0_0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive sweep; upper carry-in bits are randomized and must not matter.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int ci = 0; ci < 2; ci++) begin
          logic [W-1:0] cv;
          logic [W:0]   ref_sum;
          cv      = {3'($urandom_range(0, 7)), 1'(ci)};
          ref_sum = 5'(a + b + ci);
          drive("sweep", W'(a), W'(b), cv, ref_sum);
        end
      end
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
